// File: rtl/mem_bus_pkg.sv
// Shared definitions for the RAM bus master: bus widths, wait-state limit
// and the access FSM state encoding.
package mem_bus_pkg;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 8;
  localparam int WAIT_MAX = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } bus_state_e;

endpackage

// File: rtl/ram_bus_master.sv
// Asynchronous-SRAM bus master: turns one CPU request into a
// SETUP / STROBE (WAIT_CYCLES) / HOLD access with fully registered strobes.
module ram_bus_master
  import mem_bus_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_data_oe,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              n_cs,
  output logic              n_oe,
  output logic              n_we,
  output bus_state_e        dbg_state
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > WAIT_MAX) begin : g_bad_wait
    $error("ram_bus_master: WAIT_CYCLES=%0d outside 1..%0d", WAIT_CYCLES, WAIT_MAX);
  end

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  // Handshake: a request is taken at a rising edge where req_valid & req_ready;
  // req_ready is high only in IDLE and the request fields are latched then.
  bus_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              n_cs_q, n_cs_d;
  logic              n_oe_q, n_oe_d;
  logic              n_we_q, n_we_d;
  logic              data_oe_q, data_oe_d;
  logic              resp_valid_q, resp_valid_d;
  logic              req_ready_q, req_ready_d;

  // Output next-values are computed for the state being entered, so every
  // bus pin comes straight from a flop.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    n_cs_d       = 1'b1;
    n_oe_d       = 1'b1;
    n_we_d       = 1'b1;
    data_oe_d    = 1'b0;
    resp_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d   = SETUP;
          write_d   = req_write;
          addr_d    = req_addr;
          if (req_write) wdata_d = req_wdata;
          n_cs_d    = 1'b0;
          data_oe_d = req_write;
        end
      end
      SETUP: begin
        state_d   = STROBE;
        cnt_d     = CNT_LOAD;
        n_cs_d    = 1'b0;
        n_oe_d    = write_q;
        n_we_d    = ~write_q;
        data_oe_d = write_q;
      end
      STROBE: begin
        n_cs_d    = 1'b0;
        data_oe_d = write_q;
        if (cnt_q == 4'd0) begin
          state_d      = HOLD;
          resp_valid_d = 1'b1;
          if (!write_q) rdata_d = ram_rdata;
        end else begin
          cnt_d  = cnt_q - 4'd1;
          n_oe_d = write_q;
          n_we_d = ~write_q;
        end
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      n_cs_q       <= 1'b1;
      n_oe_q       <= 1'b1;
      n_we_q       <= 1'b1;
      data_oe_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      req_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      n_cs_q       <= n_cs_d;
      n_oe_q       <= n_oe_d;
      n_we_q       <= n_we_d;
      data_oe_q    <= data_oe_d;
      resp_valid_q <= resp_valid_d;
      req_ready_q  <= req_ready_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = rdata_q;
  assign ram_address = addr_q;
  assign ram_wdata   = wdata_q;
  assign ram_data_oe = data_oe_q;
  assign n_cs        = n_cs_q;
  assign n_oe        = n_oe_q;
  assign n_we        = n_we_q;
  assign dbg_state   = state_q;

endmodule
